// File: rtl/word_serializer.sv
// Parallel-to-serial unloader: captures a WIDTH-bit word and streams it out LSB beat first
// over a valid/ready handshake. Define WORD_SERIALIZER_SKID_EN for a one-word holding register.
module word_serializer #(
    parameter int WIDTH = 32,
    parameter int BEAT  = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    LD_EN,
    input  logic signed [WIDTH-1:0] Data_In,
    output logic                    Ld_Ready,
    output logic [BEAT-1:0]         Beat_Out,
    output logic                    Beat_Valid,
    input  logic                    Beat_Ready,
    output logic                    Beat_Last,
    output logic [15:0]             Words_Sent
);

    localparam int NBEATS = WIDTH / BEAT;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        words_q, words_d;
    logic               load, xfer, is_last;

`ifdef WORD_SERIALIZER_SKID_EN
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               skid_full_q, skid_full_d;

    assign Ld_Ready = !skid_full_q;
`else
    assign Ld_Ready = (state_q == IDLE);
`endif

    // Handshake outputs decode registered state only; Beat_Ready never reaches them.
    assign Beat_Valid = (state_q == SHIFT);
    assign Beat_Out   = Beat_Valid ? sh_q[BEAT-1:0] : '0;
    assign Beat_Last  = Beat_Valid && (idx_q == LAST_IDX);
    assign Words_Sent = words_q;

    assign load    = LD_EN && Ld_Ready;
    assign xfer    = Beat_Valid && Beat_Ready;
    assign is_last = (idx_q == LAST_IDX);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        words_d = words_q;
`ifdef WORD_SERIALIZER_SKID_EN
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    sh_d    = $unsigned(Data_In);
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && !is_last) begin
                    sh_d  = sh_q >> BEAT;
                    idx_d = idx_q + IDX_W'(1);
                end
`ifdef WORD_SERIALIZER_SKID_EN
                if (xfer && is_last) begin
                    words_d = words_q + 16'd1;
                    idx_d   = '0;
                    if (skid_full_q) begin
                        sh_d        = skid_q;
                        skid_full_d = 1'b0;
                    end else if (load) begin
                        sh_d = $unsigned(Data_In);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (load) begin
                    skid_d      = $unsigned(Data_In);
                    skid_full_d = 1'b1;
                end
`else
                if (xfer && is_last) begin
                    words_d = words_q + 16'd1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; the comb block above uses blocking.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            words_q <= '0;
`ifdef WORD_SERIALIZER_SKID_EN
            skid_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            words_q <= words_d;
`ifdef WORD_SERIALIZER_SKID_EN
            skid_full_q <= skid_full_d;
`endif
        end
    end

`ifdef WORD_SERIALIZER_SKID_EN
    // NOTE: pure data storage needs no reset; skid_full_q alone says whether it is meaningful.
    always_ff @(posedge Clk) begin
        skid_q <= skid_d;
    end
`endif

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial unloader for signed data words in the LBM datapath. It is the read-side counterpart of the 32-bit load register. A word presented on `Data_In` with `LD_EN` is captured and streamed out as narrow beats over a valid/ready handshake, least-significant beat first. It sits between the lattice-node result registers and the byte-wide off-chip/host output path on the DE2.

## Interface

Parameters:
- `WIDTH`, 32, data word width in bits; must be an integer multiple of `BEAT`.
- `BEAT`, 8, output beat width in bits; `NBEATS = WIDTH/BEAT` (default 4).

Ports:
- `Clk`  in  1  system clock, rising-edge active.
- `Reset`  in  1  asynchronous, active-low reset.
- `LD_EN`  in  1  load request; a word is accepted on a rising edge where `LD_EN=1` and `Ld_Ready=1`.
- `Data_In`  in  WIDTH  signed word to serialize.
- `Ld_Ready`  out  1  block can accept a word this cycle.
- `Beat_Out`  out  BEAT  current beat.
- `Beat_Valid`  out  1  `Beat_Out` holds a valid beat.
- `Beat_Ready`  in  1  downstream accepts the beat.
- `Beat_Last`  out  1  current beat is beat `NBEATS-1` of the word.
- `Words_Sent`  out  16  count of fully transferred words; wraps from 0xFFFF to 0x0000.

## Operation

- States: `IDLE` and `SHIFT`. Internals are a shift register `sh[WIDTH-1:0]` and a beat index `idx` (0..NBEATS-1).
- Reset (asynchronous, `Reset=0`):
  - State goes to `IDLE`.
  - `sh`, `idx`, `Beat_Out`, `Beat_Valid`, `Beat_Last` and `Words_Sent` all clear to 0.
  - `Ld_Ready=1`.
  - Reset takes effect immediately, even mid-word; the partial word is discarded.
- `IDLE`, load accepted:
  - `sh <= Data_In`, `idx <= 0`, go to `SHIFT`.
- `SHIFT`:
  - `Beat_Valid=1` and `Beat_Out = sh[BEAT-1:0]`.
  - `Beat_Last = (idx == NBEATS-1)`.
  - `Beat_Out` and `Beat_Last` stay stable until a transfer (`Beat_Valid & Beat_Ready`).
- Transfer with `idx < NBEATS-1`:
  - `sh <= sh >> BEAT` (logical shift; sign is carried only in the top beat's bits).
  - `idx <= idx+1`.
- Transfer with `idx == NBEATS-1`:
  - `Words_Sent <= Words_Sent+1`.
  - Next word source is chosen per Configuration; if there is none, go to `IDLE`.
- `LD_EN` while `Ld_Ready=0` is ignored, with no side effects.
- `Data_In` is sampled only on the accepting edge.

## Timing

- Load accepted at edge k: `Beat_Valid=1` from just after edge k; the first beat can transfer at edge k+1.
- With `Beat_Ready` held high, a word takes `NBEATS` transfer cycles (4 at defaults).
- Without skid:
  - `Ld_Ready = (state==IDLE)`.
  - Back-to-back words cost `NBEATS+1` cycles each, i.e. one bubble cycle.
- Backpressure (`Beat_Ready=0`) stalls indefinitely with no loss or duplication of beats.
- `Ld_Ready` and `Beat_Valid` are registered-state decodes, with no combinational path from `Beat_Ready`.

## Configuration

- Macro: `WORD_SERIALIZER_SKID_EN`.
- Defined: adds one holding register (`skid`, `skid_full`).
  - `Ld_Ready = !skid_full`.
  - In `IDLE`, a load goes directly to `sh`.
  - In `SHIFT`, a load goes to `skid`.
  - On the last-beat transfer: if `skid_full`, then `sh <= skid`, `skid_full <= 0`, `idx <= 0` and the state stays `SHIFT`.
  - On the last-beat transfer with `skid_full=0` and a simultaneous accepted load, `Data_In` goes directly to `sh` and the state stays `SHIFT`.
  - Result: zero-bubble streaming at `NBEATS` cycles per word.
  - Reset clears `skid_full`.
- Undefined: no holding register; behaviour is exactly as in Operation/Timing with the one-cycle bubble.

## Test plan

- Reset: assert `Reset=0` during beat 2 of word 0x12345678 -> immediately `Beat_Valid=0`, `Words_Sent=0`, `Ld_Ready=1`. After release, no stale beats appear.
- Basic: load 0x12345678 with `Beat_Ready=1` -> beats 0x78, 0x56, 0x34, 0x12 on consecutive cycles; `Beat_Last` only on 0x12; `Words_Sent=1`.
- Backpressure: same word, `Beat_Ready=0` for 3 cycles while 0x56 is presented -> `Beat_Out` holds 0x56 with `Beat_Valid=1`; the sequence resumes unchanged.
- Negative value: load 0x80000001 (signed -2147483647) -> beats 0x01, 0x00, 0x00, 0x80.
- Back-to-back: load 0xDEADBEEF, then 0x00000001 as early as `Ld_Ready` allows, `Beat_Ready=1`.
  - With `WORD_SERIALIZER_SKID_EN`: 8 contiguous beats EF, BE, AD, DE, 01, 00, 00, 00.
  - Without: exactly one cycle with `Beat_Valid=0` between DE and 01.
  - `Words_Sent=2` in both builds.
- Ignored load: pulse `LD_EN` with 0xFFFFFFFF while `Ld_Ready=0` -> no effect on the beat stream or on `Words_Sent`.
